ahb_burst_planner: RTL and testbench
====================================

Name: ahb_burst_planner

Overview:
Sequential burst planner for the AHB manager. It accepts one linear transfer request (start address, beat count, HSIZE) and emits an ordered stream of burst commands (HBURST, start address, beat count). Each burst is the largest legal fixed burst that fits the remaining beats and does not cross a parametrised address boundary. The block sits between the manager's request front-end and the HTRANS/HADDR sequencer. It replaces the per-cycle combinational burst/boundary functions with a handshaked, width/boundary/burst-limit configurable unit.

Parameters:
ADDR_W, 32, address width in bits.
LEN_W, 16, beat-count width.
BOUNDARY_LOG2, 10, bursts must not cross a 2^BOUNDARY_LOG2-byte boundary (1 KB default).
MAX_BEATS, 16, largest fixed burst allowed; legal values 4, 8 or 16.
ALLOW_INCR, 1, 1: residual chunks are INCR (undefined length); 0: residual chunks are issued as SINGLE, one beat each.

Ports:
i_hclk  in  1  clock.
i_hreset  in  1  asynchronous reset, active-high.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request accepted when valid&ready.
i_req_addr  in  ADDR_W  start byte address.
i_req_beats  in  LEN_W  total beats; 0 = empty request.
i_req_size  in  3  HSIZE encoding (W8..W1024); must satisfy size <= BOUNDARY_LOG2.
o_cmd_valid  out  1  burst command valid.
i_cmd_ready  in  1  downstream accepts the command when valid&ready.
o_cmd_addr  out  ADDR_W  burst start address.
o_cmd_hburst  out  3  SINGLE=0, INCR=1, INCR4=3, INCR8=5, INCR16=7.
o_cmd_beats  out  LEN_W  beats in this burst (4/8/16 for fixed bursts).
o_cmd_size  out  3  latched HSIZE.
o_cmd_last  out  1  final command of the current request.
o_busy  out  1  request in progress.

Behaviour:
- Reset (async, i_hreset=1): state=IDLE; all outputs 0 except o_req_ready=0 while in reset. o_req_ready=1 from the first cycle after reset deassertion. Any in-flight request is discarded.
- States: IDLE, CMD.
- IDLE:
  - o_req_ready=1, o_cmd_valid=0, o_busy=0.
  - On accept with beats!=0: latch addr with its low size bits cleared (alignment forced), rem=beats, size. Next cycle enters CMD.
  - On accept with beats==0: no command; stays IDLE.
- CMD:
  - o_req_ready=0, o_busy=1, o_cmd_valid=1.
  - All o_cmd_* fields are derived only from registered addr/rem/size, so they are stable while valid&!ready.
  - Latency: first command is valid one cycle after accept.
- Burst selection (bytes = 1<<size, blk(x) = x>>BOUNDARY_LOG2):
  - Pick the largest N in {16,8,4} with N<=MAX_BEATS, rem>=N and blk(addr)==blk(addr+N*bytes-1). Output hburst = INCR16/INCR8/INCR4, beats=N.
  - Otherwise take the residual chunk: R = min(rem, (2^BOUNDARY_LOG2 - addr[BOUNDARY_LOG2-1:0]) >> size).
    - ALLOW_INCR=1: hburst=INCR, beats=R.
    - ALLOW_INCR=0: hburst=SINGLE, beats=1.
  - Boundary arithmetic is done at ADDR_W+1 bits so the end address does not wrap falsely at the top of the address space.
- On a command handshake:
  - addr += beats<<size (modulo 2^ADDR_W).
  - rem -= beats.
  - o_cmd_last=1 when beats==rem. On that handshake, return to IDLE.
- Back-to-back requests: there is one IDLE cycle (req_ready=1) between the last command and the next request's first command.
- Reset during CMD: command dropped immediately; downstream must tolerate the lost command.
- i_req_* inputs are ignored outside IDLE.

Test Plan:
- addr 0x000, beats 40, size 2 -> INCR16@0x000, INCR16@0x040, INCR8@0x080 (last=1); o_busy low the cycle after.
- addr 0x3F0, beats 20, size 2 -> INCR4@0x3F0 (INCR8/16 would cross 0x400), then INCR16@0x400 last=1.
- addr 0x3F8, beats 3, size 2:
  - ALLOW_INCR=1 -> INCR beats=2 @0x3F8, INCR beats=1 @0x400 last.
  - ALLOW_INCR=0 -> SINGLE@0x3F8, @0x3FC, @0x400 last.
- MAX_BEATS=8, addr 0x000, beats 16, size 0 -> INCR8@0x000, INCR8@0x008 last; no INCR16 ever issued.
- Backpressure: i_cmd_ready low 5 cycles mid-request -> o_cmd_valid held high with addr/hburst/beats unchanged; after ready, sequence identical to the unstalled run.
- Boundary/reset cases:
  - beats=0 -> accepted, no o_cmd_valid, o_req_ready stays 1.
  - Assert i_hreset during the 2nd command of case 1 -> all outputs 0 asynchronously; after release, IDLE with o_req_ready=1 and no residual command.

Source files
------------

// File: rtl/ahb_burst_planner.sv
// AHB burst planner.
// Splits one linear transfer request into an ordered stream of burst commands.
// Each command is the largest allowed fixed burst that fits the remaining beats
// and stays inside one 2^BOUNDARY_LOG2-byte block. When no fixed burst fits,
// the leftover is issued as INCR, or as SINGLE beats when ALLOW_INCR=0.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a request; o_req_ready high after reset release
//   CMD   | presenting the burst command built from addr_q/rem_q/size_q
module ahb_burst_planner #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned LEN_W         = 16,
  parameter int unsigned BOUNDARY_LOG2 = 10,
  parameter int unsigned MAX_BEATS     = 16,
  parameter bit          ALLOW_INCR    = 1'b1
) (
  input  logic              i_hclk,
  input  logic              i_hreset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LEN_W-1:0]  i_req_beats,
  input  logic [2:0]        i_req_size,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [2:0]        o_cmd_hburst,
  output logic [LEN_W-1:0]  o_cmd_beats,
  output logic [2:0]        o_cmd_size,
  output logic              o_cmd_last,
  output logic              o_busy
);

  localparam int unsigned AW1 = ADDR_W + 1;
  localparam int unsigned BW  = BOUNDARY_LOG2 + 1;
  localparam int unsigned CW  = (LEN_W > BW) ? LEN_W : BW;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    CMD  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [2:0]        size_q;
  logic              rdy_en;

  logic              in_cmd;
  logic              req_ready;
  logic              cmd_fire;
  logic              is_last;
  logic [2:0]        hburst_c;
  logic [LEN_W-1:0]  beats_c;

  // True when a burst of span bytes starting at a stays inside one block.
  // Done at ADDR_W+1 bits so a burst ending at the top of memory does not wrap.
  function automatic logic same_blk(input logic [AW1-1:0] a,
                                    input logic [AW1-1:0] span);
    logic [AW1-1:0] e;
    e = a + span - AW1'(1);
    return (a >> BOUNDARY_LOG2) == (e >> BOUNDARY_LOG2);
  endfunction

  assign in_cmd    = (state == CMD);
  assign req_ready = (state == IDLE) && rdy_en;
  assign cmd_fire  = in_cmd && i_cmd_ready;
  assign is_last   = (beats_c == rem_q);

  // Burst selection from the registered request state only.
  always_comb begin
    logic [AW1-1:0] addr_x;
    logic           fit16;
    logic           fit8;
    logic           fit4;
    logic [BW-1:0]  room_bytes;
    logic [BW-1:0]  room_beats;
    logic [CW-1:0]  rem_w;
    logic [CW-1:0]  room_w;
    logic [CW-1:0]  resid;

    hburst_c   = HB_SINGLE;
    beats_c    = LEN_W'(1);
    addr_x     = {1'b0, addr_q};

    fit16 = (MAX_BEATS >= 16) && (rem_q >= LEN_W'(16)) &&
            same_blk(addr_x, AW1'(16) << size_q);
    fit8  = (MAX_BEATS >= 8) && (rem_q >= LEN_W'(8)) &&
            same_blk(addr_x, AW1'(8) << size_q);
    fit4  = (rem_q >= LEN_W'(4)) &&
            same_blk(addr_x, AW1'(4) << size_q);

    room_bytes = (BW'(1) << BOUNDARY_LOG2) - {1'b0, addr_q[BOUNDARY_LOG2-1:0]};
    room_beats = room_bytes >> size_q;
    rem_w      = CW'(rem_q);
    room_w     = CW'(room_beats);
    resid      = (rem_w < room_w) ? rem_w : room_w;

    if (fit16) begin
      hburst_c = HB_INCR16;
      beats_c  = LEN_W'(16);
    end else if (fit8) begin
      hburst_c = HB_INCR8;
      beats_c  = LEN_W'(8);
    end else if (fit4) begin
      hburst_c = HB_INCR4;
      beats_c  = LEN_W'(4);
    end else if (ALLOW_INCR) begin
      hburst_c = HB_INCR;
      beats_c  = LEN_W'(resid);
    end else begin
      hburst_c = HB_SINGLE;
      beats_c  = LEN_W'(1);
    end
  end

  // Request latch, per-command advance and IDLE/CMD sequencing.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state  <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      size_q <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: begin
          if (i_req_valid && req_ready && (i_req_beats != '0)) begin
            addr_q <= i_req_addr &
                      ~((ADDR_W'(1) << i_req_size) - ADDR_W'(1));
            rem_q  <= i_req_beats;
            size_q <= i_req_size;
            state  <= CMD;
          end
        end
        CMD: begin
          if (cmd_fire) begin
            addr_q <= addr_q + (ADDR_W'(beats_c) << size_q);
            rem_q  <= rem_q - beats_c;
            if (is_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = req_ready;
  assign o_busy       = in_cmd;
  assign o_cmd_valid  = in_cmd;
  assign o_cmd_addr   = in_cmd ? addr_q   : '0;
  assign o_cmd_hburst = in_cmd ? hburst_c : 3'd0;
  assign o_cmd_beats  = in_cmd ? beats_c  : '0;
  assign o_cmd_size   = in_cmd ? size_q   : 3'd0;
  assign o_cmd_last   = in_cmd && is_last;

endmodule

// File: tb/tb_ahb_burst_planner.sv
// Directed bench for ahb_burst_planner: three instances cover the default
// build, ALLOW_INCR=0 and MAX_BEATS=8.
module tb_ahb_burst_planner;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr;
  logic [15:0] req_beats;
  logic [2:0]  req_size;
  logic        cmd_valid  [3];
  logic        cmd_ready  [3];
  logic [31:0] cmd_addr   [3];
  logic [2:0]  cmd_hburst [3];
  logic [15:0] cmd_beats  [3];
  logic [2:0]  cmd_size   [3];
  logic        cmd_last   [3];
  logic        busy       [3];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_burst_planner #(.ALLOW_INCR(1'b1), .MAX_BEATS(16)) u_def (
    .i_hclk(clk), .i_hreset(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(req_addr), .i_req_beats(req_beats), .i_req_size(req_size),
    .o_cmd_valid(cmd_valid[0]), .i_cmd_ready(cmd_ready[0]),
    .o_cmd_addr(cmd_addr[0]), .o_cmd_hburst(cmd_hburst[0]),
    .o_cmd_beats(cmd_beats[0]), .o_cmd_size(cmd_size[0]),
    .o_cmd_last(cmd_last[0]), .o_busy(busy[0]));

  ahb_burst_planner #(.ALLOW_INCR(1'b0), .MAX_BEATS(16)) u_single (
    .i_hclk(clk), .i_hreset(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(req_addr), .i_req_beats(req_beats), .i_req_size(req_size),
    .o_cmd_valid(cmd_valid[1]), .i_cmd_ready(cmd_ready[1]),
    .o_cmd_addr(cmd_addr[1]), .o_cmd_hburst(cmd_hburst[1]),
    .o_cmd_beats(cmd_beats[1]), .o_cmd_size(cmd_size[1]),
    .o_cmd_last(cmd_last[1]), .o_busy(busy[1]));

  ahb_burst_planner #(.ALLOW_INCR(1'b1), .MAX_BEATS(8)) u_max8 (
    .i_hclk(clk), .i_hreset(rst),
    .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_addr(req_addr), .i_req_beats(req_beats), .i_req_size(req_size),
    .o_cmd_valid(cmd_valid[2]), .i_cmd_ready(cmd_ready[2]),
    .o_cmd_addr(cmd_addr[2]), .o_cmd_hburst(cmd_hburst[2]),
    .o_cmd_beats(cmd_beats[2]), .o_cmd_size(cmd_size[2]),
    .o_cmd_last(cmd_last[2]), .o_busy(busy[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request to instance d; first command must be valid one cycle later.
  task automatic do_req(input int d, input logic [31:0] a, input logic [15:0] b,
                        input logic [2:0] s);
    @(negedge clk);
    req_addr     = a;
    req_beats    = b;
    req_size     = s;
    req_valid[d] = 1'b1;
    chk($sformatf("d%0d req_ready_before", d), 64'(req_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    if (b != 16'd0) begin
      chk($sformatf("d%0d first_valid_latency", d), 64'(cmd_valid[d]), 64'd1);
      chk($sformatf("d%0d busy_in_cmd", d), 64'(busy[d]), 64'd1);
      chk($sformatf("d%0d req_ready_in_cmd", d), 64'(req_ready[d]), 64'd0);
    end
  endtask

  // Wait (bounded) for a command on instance d, check it, then hand it off.
  task automatic expect_cmd(input int d, input string tag, input logic [31:0] a,
                            input logic [2:0] hb, input logic [15:0] b,
                            input logic l, input logic [2:0] s);
    for (int k = 0; k < 20 && cmd_valid[d] !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"},  64'(cmd_valid[d]),  64'd1);
    chk({tag, "_addr"},   64'(cmd_addr[d]),   64'(a));
    chk({tag, "_hburst"}, 64'(cmd_hburst[d]), 64'(hb));
    chk({tag, "_beats"},  64'(cmd_beats[d]),  64'(b));
    chk({tag, "_last"},   64'(cmd_last[d]),   64'(l));
    chk({tag, "_size"},   64'(cmd_size[d]),   64'(s));
    cmd_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready[d] = 1'b0;
    if (l) begin
      chk({tag, "_busy_after"},  64'(busy[d]),      64'd0);
      chk({tag, "_valid_after"}, 64'(cmd_valid[d]), 64'd0);
      chk({tag, "_ready_after"}, 64'(req_ready[d]), 64'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_addr  = '0;
    req_beats = '0;
    req_size  = '0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      cmd_ready[i] = 1'b0;
    end

    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d rst_req_ready", i), 64'(req_ready[i]), 64'd0);
      chk($sformatf("d%0d rst_valid", i),     64'(cmd_valid[i]), 64'd0);
      chk($sformatf("d%0d rst_busy", i),      64'(busy[i]),      64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(req_ready[0]), 64'd1);

    // Case 1: 40 beats of words from 0x000.
    do_req(0, 32'h000, 16'd40, 3'd2);
    expect_cmd(0, "c1_0", 32'h000, 3'd7, 16'd16, 1'b0, 3'd2);
    expect_cmd(0, "c1_1", 32'h040, 3'd7, 16'd16, 1'b0, 3'd2);
    expect_cmd(0, "c1_2", 32'h080, 3'd5, 16'd8,  1'b1, 3'd2);

    // Case 2: 1 KB boundary forces an INCR4 first.
    do_req(0, 32'h3F0, 16'd20, 3'd2);
    expect_cmd(0, "c2_0", 32'h3F0, 3'd3, 16'd4,  1'b0, 3'd2);
    expect_cmd(0, "c2_1", 32'h400, 3'd7, 16'd16, 1'b1, 3'd2);

    // Case 3: residual chunks, INCR build.
    do_req(0, 32'h3F8, 16'd3, 3'd2);
    expect_cmd(0, "c3i_0", 32'h3F8, 3'd1, 16'd2, 1'b0, 3'd2);
    expect_cmd(0, "c3i_1", 32'h400, 3'd1, 16'd1, 1'b1, 3'd2);

    // Case 3: residual chunks, SINGLE build.
    do_req(1, 32'h3F8, 16'd3, 3'd2);
    expect_cmd(1, "c3s_0", 32'h3F8, 3'd0, 16'd1, 1'b0, 3'd2);
    expect_cmd(1, "c3s_1", 32'h3FC, 3'd0, 16'd1, 1'b0, 3'd2);
    expect_cmd(1, "c3s_2", 32'h400, 3'd0, 16'd1, 1'b1, 3'd2);

    // Case 4: MAX_BEATS=8 never issues INCR16.
    do_req(2, 32'h000, 16'd16, 3'd0);
    expect_cmd(2, "c4_0", 32'h000, 3'd5, 16'd8, 1'b0, 3'd0);
    expect_cmd(2, "c4_1", 32'h008, 3'd5, 16'd8, 1'b1, 3'd0);

    // Unaligned start address is aligned down to the transfer size.
    do_req(0, 32'h103, 16'd4, 3'd2);
    expect_cmd(0, "align", 32'h100, 3'd3, 16'd4, 1'b1, 3'd2);

    // Backpressure: hold the second command for 5 cycles.
    do_req(0, 32'h000, 16'd40, 3'd2);
    expect_cmd(0, "bp_0", 32'h000, 3'd7, 16'd16, 1'b0, 3'd2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_valid", k),  64'(cmd_valid[0]),  64'd1);
      chk($sformatf("bp_hold%0d_addr", k),   64'(cmd_addr[0]),   64'h40);
      chk($sformatf("bp_hold%0d_hburst", k), 64'(cmd_hburst[0]), 64'd7);
      chk($sformatf("bp_hold%0d_beats", k),  64'(cmd_beats[0]),  64'd16);
      @(posedge clk);
      #1;
    end
    expect_cmd(0, "bp_1", 32'h040, 3'd7, 16'd16, 1'b0, 3'd2);
    expect_cmd(0, "bp_2", 32'h080, 3'd5, 16'd8,  1'b1, 3'd2);

    // Empty request: accepted, no command.
    do_req(0, 32'h200, 16'd0, 3'd2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("empty%0d_valid", k), 64'(cmd_valid[0]), 64'd0);
      chk($sformatf("empty%0d_ready", k), 64'(req_ready[0]), 64'd1);
      chk($sformatf("empty%0d_busy", k),  64'(busy[0]),      64'd0);
      @(posedge clk);
      #1;
    end

    // Reset during the second command of case 1.
    do_req(0, 32'h000, 16'd40, 3'd2);
    expect_cmd(0, "rc_0", 32'h000, 3'd7, 16'd16, 1'b0, 3'd2);
    chk("rc_second_valid", 64'(cmd_valid[0]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rc_async_valid",  64'(cmd_valid[0]),  64'd0);
    chk("rc_async_addr",   64'(cmd_addr[0]),   64'd0);
    chk("rc_async_hburst", 64'(cmd_hburst[0]), 64'd0);
    chk("rc_async_beats",  64'(cmd_beats[0]),  64'd0);
    chk("rc_async_size",   64'(cmd_size[0]),   64'd0);
    chk("rc_async_last",   64'(cmd_last[0]),   64'd0);
    chk("rc_async_busy",   64'(busy[0]),       64'd0);
    chk("rc_async_ready",  64'(req_ready[0]),  64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rc_post_ready", 64'(req_ready[0]), 64'd1);
    chk("rc_post_valid", 64'(cmd_valid[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("rc_post_valid2", 64'(cmd_valid[0]), 64'd0);
    chk("rc_post_busy",   64'(busy[0]),      64'd0);

    // Fresh request after reset runs normally.
    do_req(0, 32'h3F0, 16'd20, 3'd2);
    expect_cmd(0, "pr_0", 32'h3F0, 3'd3, 16'd4,  1'b0, 3'd2);
    expect_cmd(0, "pr_1", 32'h400, 3'd7, 16'd16, 1'b1, 3'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
